// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
// Default widths and round-robin pointer encoding.
package regfile_wr_arbiter_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int ADDR_WIDTH_DEF = 2;

    typedef enum logic {
        RR_REQ0 = 1'b0,
        RR_REQ1 = 1'b1
    } rr_ptr_e;

endpackage

// File: rtl/regfile_wr_arbiter_fifo2.sv
// Two-entry write queue; entry 0 is always the head.
// Exposes per-entry valid/address taps for pending-register tracking.
module regwr_fifo2 #(
    parameter int DW = 32,
    parameter int AW = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [AW-1:0]      push_addr,
    input  logic [DW-1:0]      push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [1:0]         count,
    output logic [AW-1:0]      head_addr,
    output logic [DW-1:0]      head_data,
    output logic [1:0]         ent_valid,
    output logic [1:0][AW-1:0] ent_addr
);

    logic [1:0]         count_q, count_d;
    logic [1:0][AW-1:0] addr_q, addr_d;
    logic [1:0][DW-1:0] data_q, data_d;
    logic               do_push, do_pop;

    assign do_push = push && (count_q != 2'd2);
    assign do_pop  = pop && (count_q != 2'd0);

    always_comb begin
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (flush) begin
            count_d = 2'd0;
        end else begin
            if (do_pop) begin
                addr_d[0] = addr_q[1];
                data_d[0] = data_q[1];
            end
            // A simultaneous pop frees slot 0 for the incoming entry.
            if (do_push) begin
                if (count_q == 2'd1 && !do_pop) begin
                    addr_d[1] = push_addr;
                    data_d[1] = push_data;
                end else begin
                    addr_d[0] = push_addr;
                    data_d[0] = push_data;
                end
            end
            count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign count     = count_q;
    assign head_addr = addr_q[0];
    assign head_data = data_q[0];
    assign ent_valid = {count_q == 2'd2, count_q != 2'd0};
    assign ent_addr  = addr_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-requester register-file write arbiter: per-requester queues,
// round-robin grant, and a registered write port.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    localparam int NREG = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    input  logic                  flush,
    output logic                  wena,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [NREG-1:0]       pend_mask
);

    logic [1:0]                 cnt0, cnt1;
    logic [ADDR_WIDTH-1:0]      head_addr0, head_addr1;
    logic [DATA_WIDTH-1:0]      head_data0, head_data1;
    logic [1:0]                 ev0, ev1;
    logic [1:0][ADDR_WIDTH-1:0] ea0, ea1;
    logic                       push0, push1, gnt0, gnt1;
    rr_ptr_e                    rr_q, rr_d;
    logic                       wena_q, wena_d;
    logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;

    assign req0_ready = (cnt0 != 2'd2);
    assign req1_ready = (cnt1 != 2'd2);
    assign push0 = req0_valid && req0_ready && !flush;
    assign push1 = req1_valid && req1_ready && !flush;

    regwr_fifo2 #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_fifo0 (
        .clk(clk), .rst_n(rst_n),
        .push(push0), .push_addr(req0_addr), .push_data(req0_data),
        .pop(gnt0), .flush(flush), .count(cnt0),
        .head_addr(head_addr0), .head_data(head_data0),
        .ent_valid(ev0), .ent_addr(ea0)
    );

    regwr_fifo2 #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_fifo1 (
        .clk(clk), .rst_n(rst_n),
        .push(push1), .push_addr(req1_addr), .push_data(req1_data),
        .pop(gnt1), .flush(flush), .count(cnt1),
        .head_addr(head_addr1), .head_data(head_data1),
        .ent_valid(ev1), .ent_addr(ea1)
    );

    always_comb begin
        gnt0 = !flush && (cnt0 != 2'd0) &&
               ((cnt1 == 2'd0) || (rr_q == RR_REQ0));
        gnt1 = !flush && (cnt1 != 2'd0) &&
               ((cnt0 == 2'd0) || (rr_q == RR_REQ1));
    end

    always_comb begin
        rr_d    = rr_q;
        wena_d  = gnt0 || gnt1;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (flush) begin
            rr_d = RR_REQ0;
        end
        unique case (1'b1)
            gnt0: begin
                rr_d    = RR_REQ1;
                waddr_d = head_addr0;
                wdata_d = head_data0;
            end
            gnt1: begin
                rr_d    = RR_REQ0;
                waddr_d = head_addr1;
                wdata_d = head_data1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_q    <= RR_REQ0;
            wena_q  <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            rr_q    <= rr_d;
            wena_q  <= wena_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int e = 0; e < 2; e++) begin
            if (ev0[e]) pend_mask[ea0[e]] = 1'b1;
            if (ev1[e]) pend_mask[ea1[e]] = 1'b1;
        end
        if (wena_q) pend_mask[waddr_q] = 1'b1;
    end

    assign wena  = wena_q;
    assign waddr = waddr_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed self-checking bench for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;

    localparam int DW = 32;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_addr, req1_addr;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic          flush;
    logic          wena;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [3:0]    pend_mask;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] rf [4];

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .flush(flush), .wena(wena), .waddr(waddr), .wdata(wdata),
        .pend_mask(pend_mask)
    );

    always @(posedge clk) if (wena) rf[waddr] <= wdata;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic do_reset;
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Both requesters valid every cycle, starting right after reset.
    task automatic run_contention(input int ncyc, input string pfx);
        int k0 = 0;
        int k1 = 0;
        bit x0, x1;
        req0_addr  = 2'd1;
        req1_addr  = 2'd2;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            req0_data = 32'hA000_0000 + k0;
            req1_data = 32'hB000_0000 + k1;
            x0 = req0_ready;
            x1 = req1_ready;
            tick();
            if (x0) k0++;
            if (x1) k1++;
            if (n == 1) begin
                chk({pfx, "_wena1"}, wena, 0);
            end else if (n % 2 == 0) begin
                chk({pfx, "_wena"}, wena, 1);
                chk({pfx, "_waddr0"}, waddr, 1);
                chk({pfx, "_wdata0"}, wdata, 32'hA000_0000 + (n - 2) / 2);
            end else begin
                chk({pfx, "_wena"}, wena, 1);
                chk({pfx, "_waddr1"}, waddr, 2);
                chk({pfx, "_wdata1"}, wdata, 32'hB000_0000 + (n - 3) / 2);
            end
            if (n >= 3) chk({pfx, "_rdy0"}, req0_ready, (n % 2 == 0));
            if (n >= 2) chk({pfx, "_rdy1"}, req1_ready, (n % 2 == 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int seen;
        int k1;
        int leaks;
        bit x1;
        req0_addr = '0;
        req1_addr = '0;
        req0_data = '0;
        req1_data = '0;
        do_reset();

        chk("rst_rdy0", req0_ready, 1);
        chk("rst_rdy1", req1_ready, 1);
        chk("rst_wena", wena, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_pend", pend_mask, 0);

        // Single write latency and pending mask
        req0_valid = 1'b1;
        req0_addr  = 2'd2;
        req0_data  = 32'hDEAD_BEEF;
        tick();
        idle();
        chk("sw_pend1", pend_mask, 4'b0100);
        chk("sw_wena1", wena, 0);
        tick();
        chk("sw_wena2", wena, 1);
        chk("sw_waddr2", waddr, 2);
        chk("sw_wdata2", wdata, 32'hDEAD_BEEF);
        chk("sw_pend2", pend_mask, 4'b0100);
        tick();
        chk("sw_wena3", wena, 0);
        chk("sw_pend3", pend_mask, 0);
        chk("sw_hold3", wdata, 32'hDEAD_BEEF);

        // Contention, then reset mid-stream and restart
        do_reset();
        run_contention(9, "rr");
        rst_n = 1'b0;
        tick();
        chk("mr_wena", wena, 0);
        chk("mr_waddr", waddr, 0);
        chk("mr_wdata", wdata, 0);
        chk("mr_rdy0", req0_ready, 1);
        chk("mr_rdy1", req1_ready, 1);
        chk("mr_pend", pend_mask, 0);
        rst_n = 1'b1;
        run_contention(9, "rs");
        idle();
        tick();
        tick();
        tick();
        tick();

        // Back-pressure on req1 while req0 keeps its queue busy
        do_reset();
        seen = 0;
        k1 = 0;
        req0_valid = 1'b1;
        req0_addr  = 2'd1;
        req0_data  = 32'hA5A5_A5A5;
        req1_addr  = 2'd0;
        for (int n = 1; n <= 20; n++) begin
            req1_valid = (k1 < 4);
            req1_data  = 32'hC000_0001 + k1;
            if (n == 13) req0_valid = 1'b0;
            x1 = req1_valid && req1_ready;
            tick();
            if (x1) k1++;
            if (n == 2) begin
                chk("bp_two", k1, 2);
                chk("bp_rdy_drop", req1_ready, 0);
            end
            if (wena && waddr == 2'd0) begin
                chk("bp_order", wdata, 32'hC000_0001 + seen);
                seen++;
            end
        end
        chk("bp_count", seen, 4);
        idle();

        // Same destination from both requesters
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 2'd3;
        req0_data  = 32'h11;
        req1_valid = 1'b1;
        req1_addr  = 2'd3;
        req1_data  = 32'h22;
        tick();
        idle();
        chk("sa_pend", pend_mask, 4'b1000);
        tick();
        chk("sa_wena1", wena, 1);
        chk("sa_waddr1", waddr, 3);
        chk("sa_wdata1", wdata, 32'h11);
        tick();
        chk("sa_wena2", wena, 1);
        chk("sa_wdata2", wdata, 32'h22);
        tick();
        chk("sa_wena3", wena, 0);
        chk("sa_rf3", rf[3], 32'h22);

        // Flush with three writes outstanding
        do_reset();
        req0_valid = 1'b1;
        req0_addr  = 2'd1;
        req0_data  = 32'h1;
        req1_valid = 1'b1;
        req1_addr  = 2'd2;
        req1_data  = 32'h2;
        tick();
        req1_valid = 1'b0;
        req0_addr  = 2'd3;
        req0_data  = 32'h3;
        tick();
        chk("fl_pend_pre", pend_mask, 4'b1110);
        chk("fl_wena_pre", wena, 1);
        chk("fl_waddr_pre", waddr, 1);
        flush      = 1'b1;
        req0_valid = 1'b1;
        req0_addr  = 2'd0;
        req0_data  = 32'h99;
        req1_valid = 1'b1;
        req1_addr  = 2'd0;
        req1_data  = 32'h98;
        tick();
        idle();
        chk("fl_wena", wena, 0);
        chk("fl_pend", pend_mask, 0);
        chk("fl_rdy0", req0_ready, 1);
        chk("fl_rdy1", req1_ready, 1);
        leaks = 0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (wena) leaks++;
        end
        chk("fl_leak", leaks, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 2, register index width; register count NREG = 2**ADDR_WIDTH.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 SHALL have ports req0_valid / req1_valid  in  1  requester write request.
REQ-006 SHALL have ports req0_addr / req1_addr  in  ADDR_WIDTH  destination register.
REQ-007 SHALL have ports req0_data / req1_data  in  DATA_WIDTH  write data.
REQ-008 SHALL have ports req0_ready / req1_ready  out  1  requester may transfer; registered.
REQ-009 SHALL have port flush  in  1  discard all queued and staged writes.
REQ-010 SHALL have port wena  out  1  register-file write enable; registered.
REQ-011 SHALL have port waddr  out  ADDR_WIDTH  register-file write index; registered.
REQ-012 SHALL have port wdata  out  DATA_WIDTH  register-file write data; registered.
REQ-013 SHALL have port pend_mask  out  NREG  bit r set while any queued or staged write targets register r.

Function
REQ-014 SHALL transfer on reqN when reqN_valid and reqN_ready both high at a rising edge; no transfer otherwise.
REQ-015 SHALL hold one 2-entry FIFO per requester, occupancy 0..2; reqN_ready = (occupancy < 2), taken from registered occupancy.
REQ-016 SHALL, each cycle, grant at most one non-empty FIFO head; sole non-empty FIFO wins.
REQ-017 SHALL, when both FIFOs are non-empty, grant the requester named by a 1-bit round-robin pointer; after any grant the pointer moves to the other requester.
REQ-018 SHALL load the granted head into the output stage at the same edge that pops it; wena = 1 in the following cycle with that head's waddr/wdata; wena = 0 in any cycle after a no-grant edge.
REQ-019 SHALL give latency: transfer at edge E -> wena high in cycle after E+1 -> register file commits at edge E+2.
REQ-020 SHALL allow push and pop of the same FIFO at one edge; occupancy unchanged, order preserved.
REQ-021 SHALL sustain one accepted write per cycle per requester when that requester alone is active.
REQ-022 SHALL preserve per-requester write order; no ordering between requesters beyond the round-robin rule.
REQ-023 SHALL treat same-address requests from both requesters as independent; the later-granted write lands last.
REQ-024 SHALL compute pend_mask combinationally from valid FIFO entries plus the output stage while wena = 1.
REQ-025 SHALL, on flush = 1 at an edge: empty both FIFOs, clear wena, reset the pointer to 0, accept nothing. In the following cycle ready = 1 and pend_mask = 0.
REQ-026 SHALL ignore reqN_addr/reqN_data when no transfer occurs; waddr/wdata are don't-care while wena = 0 but SHALL hold their last value.

Reset
REQ-027 SHALL, at a rising edge with rst_n = 0: occupancies 0, pointer 0, wena 0, waddr 0, wdata 0; reset overrides flush and transfers.
REQ-028 SHALL, after reset, show req0_ready = req1_ready = 1 and pend_mask = 0; reset mid-operation drops all queued writes.

Structure
REQ-029 SHALL place the default widths and the round-robin pointer encoding (RR_REQ0 = 0, RR_REQ1 = 1) in the shared processor package.
REQ-030 SHALL instantiate one sub-module regwr_fifo2 (2-entry FIFO, push/pop/flush, count, head, entry-valid/address taps) twice; arbitration and the output stage live in the top module.

Verification
REQ-031 Single write: req0 addr 2 data 0xDEADBEEF at edge 1 -> wena = 1, waddr = 2, wdata = 0xDEADBEEF in the cycle after edge 2; pend_mask = 4'b0100 after edges 1 and 2, 0 after edge 3.
REQ-032 Contention: both valid every cycle from reset, req0 data 0xA0.., req1 data 0xB0.. -> wena stream alternates req0, req1, req0, ...; each ready toggles as its FIFO fills to 2.
REQ-033 Back-pressure: req1 valid 4 consecutive cycles while req0 keeps FIFO0 saturated -> req1_ready drops after 2 transfers; all 4 writes emerge in order 1..4, none lost or duplicated.
REQ-034 Same address: req0 (addr 3, 0x11) and req1 (addr 3, 0x22) at the same edge, pointer 0 -> 0x11 written first, 0x22 next cycle; final reg3 = 0x22.
REQ-035 Flush: 3 writes queued, flush pulse -> wena 0 next cycle, pend_mask 0, both ready 1; no flushed write ever appears on wena.
REQ-036 Reset mid-stream: rst_n = 0 for one edge during REQ-032 traffic -> all outputs at reset values next cycle; the stream restarts with req0 granted first.
